mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 38 +++
 rtl/mdu_ctrl.sv | 147 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: shift-add multiply or restoring shift-subtract divide.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt_c,
    output logic [WIDTH-1:0] lo_nxt_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: {hi,lo} holds partial product above the remaining multiplier bits.
    // Divide: {hi,lo} holds partial remainder above the remaining dividend/quotient bits.
    always_comb begin
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted  = {hi, lo[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        hi_nxt_c = sum[WIDTH:1];
        lo_nxt_c = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                hi_nxt_c = diff[WIDTH-1:0];
                lo_nxt_c = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_c = shifted[WIDTH-1:0];
                lo_nxt_c = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: FSM, iteration counter, sign fix-up and HI/LO registers.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    mdu_state_e         state, state_nxt;
    mdu_op_e            op_e;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_acc, lo_acc, opnd;
    logic               is_div, sgn_q, sgn_r;
    logic               start_go, div_zero, sgn_op;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic [2*WIDTH-1:0] prod_neg;

    assign op_e     = mdu_op_e'(op);
    assign sgn_op   = op_is_signed(op_e);
    assign div_zero = op_is_div(op_e) && (rt_val == '0);
    assign rs_mag   = (sgn_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag   = (sgn_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign prod_neg = -{hi_acc, lo_acc};

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .hi       (hi_acc),
        .lo       (lo_acc),
        .opnd     (opnd),
        .hi_nxt_c (hi_step),
        .lo_nxt_c (lo_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush beats start in IDLE and aborts RUN/FIX; DONE always commits.
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    start_go  = 1'b1;
                    state_nxt = div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status flags track the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
        end else if (start_go) begin
            cnt    <= CNT_W'(WIDTH);
            is_div <= op_is_div(op_e);
            sgn_q  <= sgn_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            sgn_r  <= sgn_op && rs_val[WIDTH-1];
            if (div_zero) begin
                hi_acc <= rs_val;
                lo_acc <= '1;
                opnd   <= '0;
            end else if (op_is_div(op_e)) begin
                hi_acc <= '0;
                lo_acc <= rs_mag;
                opnd   <= rt_mag;
            end else begin
                hi_acc <= '0;
                lo_acc <= rt_mag;
                opnd   <= rs_mag;
            end
        end else if (state == ST_RUN) begin
            hi_acc <= hi_step;
            lo_acc <= lo_step;
            cnt    <= cnt - CNT_W'(1);
        end else if (state == ST_FIX && !flush) begin
            if (is_div) begin
                if (sgn_q) lo_acc <= -lo_acc;
                if (sgn_r) hi_acc <= -hi_acc;
            end else if (sgn_q) begin
                {hi_acc, lo_acc} <= prod_neg;
            end
        end
    end

    // Direct moves only land in IDLE and lose to a coincident start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (state == ST_DONE) begin
            hi_out <= hi_acc;
            lo_out <= lo_acc;
        end else if (state == ST_IDLE && !start) begin
            if (mthi_we) hi_out <= rs_val;
            if (mtlo_we) lo_out <= rs_val;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table of complete operations plus control-corner sequences.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in cycle n0, advance until done or a cycle budget runs out.
    task automatic wait_done(input int n0, output int n, output int nb);
        n  = n0;
        nb = 0;
        while (1) begin
            if (busy) nb++;
            if (done || n >= 60) break;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ecyc);
        int n, nb;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, n, nb);
        chk({nm, "_done_cycle"}, 32'(n), 32'(ecyc));
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(ecyc));
        tick();
        chk({nm, "_hi"}, hi_out, eh);
        chk({nm, "_lo"}, lo_out, el);
    endtask

    task automatic move(input logic [31:0] h, input logic [31:0] l);
        rs_val = h; mthi_we = 1'b1;
        tick();
        mthi_we = 1'b0; rs_val = l; mtlo_we = 1'b1;
        tick();
        mtlo_we = 1'b0;
    endtask

    initial begin
        int n, nb;
        bit saw;

        vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 34};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[5]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
        vecs[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 34};
        vecs[10] = '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 34};

        reset_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        tick();
        chk("reset_hi", hi_out, 32'h0);
        chk("reset_lo", lo_out, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // First vector starts on the very first edge after reset release.
        reset_n = 1'b1;
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);

        move(32'hA5A5A5A5, 32'h5A5A5A5A);
        chk("mthi_idle", hi_out, 32'hA5A5A5A5);
        chk("mtlo_idle", lo_out, 32'h5A5A5A5A);

        // Move strobes coincident with start are dropped.
        op = 2'b01; rs_val = 32'h2; rt_val = 32'h3; start = 1'b1; mthi_we = 1'b1; mtlo_we = 1'b1;
        tick();
        start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        chk("mt_with_start_hi", hi_out, 32'hA5A5A5A5);
        chk("mt_with_start_lo", lo_out, 32'h5A5A5A5A);
        // Start and moves while busy are ignored.
        for (int c = 1; c < 5; c++) tick();
        op = 2'b11; rs_val = 32'hDEADBEEF; rt_val = 32'h0; start = 1'b1; mthi_we = 1'b1;
        tick();
        start = 1'b0; mthi_we = 1'b0;
        wait_done(6, n, nb);
        chk("busy_start_done_cycle", 32'(n), 32'd34);
        tick();
        chk("busy_start_hi", hi_out, 32'h0);
        chk("busy_start_lo", lo_out, 32'h6);
        tick();
        chk("busy_start_no_restart", 32'(busy), 32'h0);

        // Flush mid-run: back to IDLE next cycle, no commit, then a clean restart.
        move(32'h11111111, 32'h22222222);
        op = 2'b01; rs_val = 32'h5; rt_val = 32'h6; start = 1'b1;
        tick();
        start = 1'b0; saw = 1'b0;
        for (int c = 1; c < 10; c++) begin
            saw |= done;
            tick();
        end
        saw |= done;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        saw |= done;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_no_done", 32'(saw), 32'h0);
        chk("flush_hi", hi_out, 32'h11111111);
        chk("flush_lo", lo_out, 32'h22222222);
        tick();
        run_op("after_flush", 2'b01, 32'h5, 32'h6, 32'h0, 32'd30, 34);

        // Flush together with start in IDLE: nothing starts.
        op = 2'b01; rs_val = 32'h7; rt_val = 32'h7; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'h0);
        tick();
        chk("flush_start_lo", lo_out, 32'd30);

        // Flush during DONE still commits.
        op = 2'b01; rs_val = 32'h9; rt_val = 32'h9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, n, nb);
        chk("flush_done_cycle", 32'(n), 32'd34);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_lo", lo_out, 32'd81);
        chk("flush_done_hi", hi_out, 32'h0);

        // Asynchronous reset in cycle 20 of a divide.
        op = 2'b10; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_hi", hi_out, 32'h0);
        chk("midrst_lo", lo_out, 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        rs_val = 32'h12345678; mthi_we = 1'b1;
        tick();
        mthi_we = 1'b0;
        chk("post_rst_mthi", hi_out, 32'h12345678);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            saw |= done | busy;
            tick();
        end
        chk("post_rst_quiet", 32'(saw), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
